// File: rtl/otter_mem_pkg.sv
// Shared types and constants for the OTTER memory responder.
package otter_mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2,
        MEM_ILL  = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    localparam int LATENCY_MAX = 15;

    // Size code 3 has no meaning on the OTTER bus.
    function automatic logic size_illegal(input logic [1:0] size);
        return (size == 2'd3);
    endfunction

endpackage

// File: rtl/otter_lane_align.sv
// Byte-lane placement for stores: strobe, replicated lane data, alignment flag.
module otter_lane_align
    import otter_mem_pkg::*;
(
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_strb,
    output logic [31:0] o_data,
    output logic        o_misalign
);

    // Data is replicated across lanes so the strobe alone selects the target bytes.
    always_comb begin
        o_strb     = 4'b0000;
        o_data     = 32'h0000_0000;
        o_misalign = 1'b0;
        case (i_size)
            MEM_BYTE: begin
                o_strb = 4'b0001 << i_addr;
                o_data = {4{i_wdata[7:0]}};
            end
            MEM_HALF: begin
                o_strb     = i_addr[1] ? 4'b1100 : 4'b0011;
                o_data     = {2{i_wdata[15:0]}};
                o_misalign = i_addr[0];
            end
            MEM_WORD: begin
                o_strb     = 4'b1111;
                o_data     = i_wdata;
                o_misalign = (i_addr != 2'b00);
            end
            default: begin
                o_strb     = 4'b0000;
                o_data     = 32'h0000_0000;
                o_misalign = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/otter_mem_resp.sv
// Memory-side responder for the OTTER shared instruction/data port:
// one request at a time, programmable wait cycles, byte-strobed stores.
module otter_mem_resp
    import otter_mem_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam int         LAT_C    = (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
    localparam logic [3:0] CNT_LOAD = (LAT_C > 0) ? 4'(LAT_C - 1) : 4'd0;

    mem_state_e  r_state;
    mem_state_e  w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic        r_ready;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic        r_we;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic [31:0] r_wdata;

    logic [31:0] r_mem [0:DEPTH-1];

    logic              w_accept;
    logic              w_sel_we;
    logic [31:0]       w_sel_addr;
    logic [1:0]        w_sel_size;
    logic [31:0]       w_sel_wdata;
    logic [3:0]        w_strb;
    logic [31:0]       w_lane_data;
    logic              w_misalign;
    logic              w_range_err;
    logic              w_err;
    logic [ADDR_W-1:0] w_idx;

    // r_ready is only ever high in IDLE, so it doubles as the acceptance qualifier.
    assign w_accept = req_valid & r_ready;

    // With zero latency the acceptance cycle is also the read cycle, so the
    // live bus is used in IDLE and the captured request everywhere else.
    assign w_sel_we    = (r_state == IDLE) ? req_we    : r_we;
    assign w_sel_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_sel_size  = (r_state == IDLE) ? req_size  : r_size;
    assign w_sel_wdata = (r_state == IDLE) ? req_wdata : r_wdata;

    otter_lane_align u_align (
        .i_addr     (w_sel_addr[1:0]),
        .i_size     (w_sel_size),
        .i_wdata    (w_sel_wdata),
        .o_strb     (w_strb),
        .o_data     (w_lane_data),
        .o_misalign (w_misalign)
    );

    assign w_range_err = ((w_sel_addr >> (ADDR_W + 2)) != 32'd0);
    assign w_err       = w_misalign | size_illegal(w_sel_size) | w_range_err;
    assign w_idx       = w_sel_addr[ADDR_W+1:2];

    // Next-state and wait-counter logic.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (LAT_C > 0) begin
                        w_next     = WAIT;
                        w_cnt_next = CNT_LOAD;
                    end else begin
                        w_next     = RESP;
                        w_cnt_next = 4'd0;
                    end
                end else begin
                    w_next = IDLE;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            RESP: begin
                w_next = IDLE;
            end
            default: begin
                w_next     = IDLE;
                w_cnt_next = 4'd0;
            end
        endcase
    end

    // State, counter and registered response outputs; read data is taken in the
    // cycle before RESP so a store reports the word as it was before the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_ready     <= (w_next == IDLE);
            r_rsp_valid <= (w_next == RESP);
            r_rsp_err   <= (w_next == RESP) & w_err;
            r_rsp_rdata <= ((w_next == RESP) && !w_err) ? r_mem[w_idx] : 32'h0000_0000;
        end
    end

    // Capture the request at acceptance; the bus is don't-care afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= 32'h0000_0000;
            r_size  <= 2'd0;
            r_wdata <= 32'h0000_0000;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_size  <= req_size;
            r_wdata <= req_wdata;
        end
    end

    // Byte-strobed array write, only in RESP and only for an error-free store.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == RESP) && w_sel_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_lane_data[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_otter_mem_resp.sv
// Directed bench for otter_mem_resp: three instances at LATENCY 1, 0 and 3.
module tb_otter_mem_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [1:0]  req_size  [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    genvar g;
    for (g = 0; g < 3; g++) begin : g_dut
        otter_mem_resp #(
            .ADDR_W  (12),
            .LATENCY ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_size  (req_size[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g])
        );
    end

    int checks   = 0;
    int failures = 0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        int          d;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
        string       tag;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int d, input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic [31:0] wdata, input logic chk_rd, input logic [31:0] exp_rd,
                       input logic exp_err, input string tag);
        vec_t v;
        v.d = d; v.we = we; v.addr = addr; v.size = size; v.wdata = wdata;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_err = exp_err; v.tag = tag;
        vecs.push_back(v);
    endtask

    // Called and returns at a negedge: issue one request, check latency and the pulse.
    task automatic run_req(input vec_t v);
        int n;
        n = 0;
        while (req_ready[v.d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({v.tag, " ready"}, 32'(req_ready[v.d]), 32'd1);
        if (req_ready[v.d] === 1'b1) begin
            req_valid[v.d] = 1'b1;
            req_we[v.d]    = v.we;
            req_addr[v.d]  = v.addr;
            req_size[v.d]  = v.size;
            req_wdata[v.d] = v.wdata;
            @(posedge clk);
            @(negedge clk);
            req_valid[v.d] = 1'b0;
            req_we[v.d]    = 1'($urandom);
            req_addr[v.d]  = $urandom;
            req_size[v.d]  = 2'($urandom);
            req_wdata[v.d] = $urandom;
            n = 1;
            while (rsp_valid[v.d] !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check({v.tag, " latency"}, 32'(n), 32'(lat_of(v.d) + 1));
            if (rsp_valid[v.d] === 1'b1) begin
                if (v.chk_rd) check({v.tag, " rdata"}, rsp_rdata[v.d], v.exp_rd);
                check({v.tag, " err"}, 32'(rsp_err[v.d]), 32'(v.exp_err));
                @(negedge clk);
                check({v.tag, " pulse end"}, {rsp_rdata[v.d][30:0], rsp_valid[v.d] | rsp_err[v.d] | rsp_rdata[v.d][31]}, 32'd0);
            end
        end
    endtask

    initial begin
        int pulses;
        vec_t v;

        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0;
            req_addr[d] = 32'd0; req_size[d] = 2'd0; req_wdata[d] = 32'd0;
        end

        // LATENCY=1 instance
        add(0, 1'b1, 32'h0000_0000, 2'd2, 32'h0BAD_F00D, 1'b0, 32'h0,         1'b0, "w0 init");
        add(0, 1'b1, 32'h0000_0100, 2'd2, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0, "w100 beef");
        add(0, 1'b0, 32'h0000_0100, 2'd2, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, "r100 beef");
        add(0, 1'b1, 32'h0000_0100, 2'd2, 32'h1122_3344, 1'b1, 32'hDEAD_BEEF, 1'b0, "w100 old");
        add(0, 1'b1, 32'h0000_0101, 2'd0, 32'h0000_00AA, 1'b1, 32'h1122_3344, 1'b0, "wb101");
        add(0, 1'b0, 32'h0000_0100, 2'd2, 32'h0,         1'b1, 32'h1122_AA44, 1'b0, "r after byte");
        add(0, 1'b1, 32'h0000_0102, 2'd1, 32'h0000_BEEF, 1'b1, 32'h1122_AA44, 1'b0, "wh102");
        add(0, 1'b0, 32'h0000_0100, 2'd2, 32'h0,         1'b1, 32'hBEEF_AA44, 1'b0, "r after half");
        add(0, 1'b0, 32'h0000_0102, 2'd2, 32'h0,         1'b1, 32'h0,         1'b1, "rw misalign");
        add(0, 1'b1, 32'h0000_0103, 2'd1, 32'h0000_5555, 1'b1, 32'h0,         1'b1, "wh misalign");
        add(0, 1'b0, 32'h0000_0100, 2'd3, 32'h0,         1'b1, 32'h0,         1'b1, "r size3");
        add(0, 1'b1, 32'h0000_0100, 2'd3, 32'h9999_9999, 1'b1, 32'h0,         1'b1, "w size3");
        add(0, 1'b1, 32'h0001_0000, 2'd2, 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b1, "w range");
        add(0, 1'b0, 32'h0001_0000, 2'd2, 32'h0,         1'b1, 32'h0,         1'b1, "r range");
        add(0, 1'b0, 32'h0000_0100, 2'd2, 32'h0,         1'b1, 32'hBEEF_AA44, 1'b0, "r100 unchanged");
        add(0, 1'b0, 32'h0000_0000, 2'd2, 32'h0,         1'b1, 32'h0BAD_F00D, 1'b0, "r0 unchanged");
        add(0, 1'b1, 32'h0000_0300, 2'd2, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b0, "w300 init");
        add(0, 1'b1, 32'h0000_0300, 2'd2, 32'h1234_5678, 1'b1, 32'hCAFE_F00D, 1'b0, "w300 old");
        add(0, 1'b0, 32'h0000_0300, 2'd2, 32'h0,         1'b1, 32'h1234_5678, 1'b0, "r300 new");
        // LATENCY=0 instance
        add(1, 1'b1, 32'h0000_0040, 2'd2, 32'hA0A0_A0A0, 1'b0, 32'h0,         1'b0, "l0 w40");
        add(1, 1'b0, 32'h0000_0040, 2'd2, 32'h0,         1'b1, 32'hA0A0_A0A0, 1'b0, "l0 r40");
        add(1, 1'b1, 32'h0000_0042, 2'd0, 32'h0000_0077, 1'b1, 32'hA0A0_A0A0, 1'b0, "l0 wb42");
        add(1, 1'b0, 32'h0000_0040, 2'd2, 32'h0,         1'b1, 32'hA077_A0A0, 1'b0, "l0 r40 b");
        // LATENCY=3 instance
        add(2, 1'b1, 32'h0000_0200, 2'd2, 32'h0102_0304, 1'b0, 32'h0,         1'b0, "l3 w200");
        add(2, 1'b0, 32'h0000_0200, 2'd2, 32'h0,         1'b1, 32'h0102_0304, 1'b0, "l3 r200");

        // Reset state
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst ready d%0d", d), 32'(req_ready[d]), 32'd0);
            check($sformatf("rst rsp d%0d", d),
                  {rsp_rdata[d][29:0], rsp_valid[d], rsp_err[d]}, 32'd0);
            rst[d] = 1'b0;
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("post-rst ready d%0d", d), 32'(req_ready[d]), 32'd1);
        end

        foreach (vecs[i]) run_req(vecs[i]);

        // LATENCY=0: req_valid held high for four reads
        pulses = 0;
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h0000_0040; req_size[1] = 2'd2;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("hold ready k%0d", k), 32'(req_ready[1]), 32'((k % 2) == 0));
            check($sformatf("hold valid k%0d", k), 32'(rsp_valid[1]), 32'((k % 2) == 1));
            if (rsp_valid[1] === 1'b1) begin
                pulses++;
                check($sformatf("hold rdata k%0d", k), rsp_rdata[1], 32'hA077_A0A0);
            end
            if (k == 7) req_valid[1] = 1'b0;
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            if (rsp_valid[1] === 1'b1) pulses++;
            @(negedge clk);
        end
        check("hold pulses", 32'(pulses), 32'd4);

        // LATENCY=3: reset in the second WAIT cycle of a byte store
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h0000_0200;
        req_size[2] = 2'd0; req_wdata[2] = 32'h0000_0055;
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        check("midrst wait1 valid", 32'(rsp_valid[2]), 32'd0);
        @(negedge clk);
        rst[2] = 1'b1;
        @(negedge clk);
        check("midrst ready in rst", 32'(req_ready[2]), 32'd0);
        check("midrst valid in rst", 32'(rsp_valid[2]), 32'd0);
        rst[2] = 1'b0;
        @(negedge clk);
        check("midrst ready after", 32'(req_ready[2]), 32'd1);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid[2] === 1'b1) pulses++;
            @(negedge clk);
        end
        check("midrst no pulse", 32'(pulses), 32'd0);
        v.d = 2; v.we = 1'b0; v.addr = 32'h0000_0200; v.size = 2'd2; v.wdata = 32'h0;
        v.chk_rd = 1'b1; v.exp_rd = 32'h0102_0304; v.exp_err = 1'b0; v.tag = "midrst r200";
        run_req(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/otter_mem_resp.md
Name: otter_mem_resp

Overview:
- Bus responder (memory side) for the OTTER multicycle CPU's single shared instruction/data port.
- Accepts one request at a time from the CPU (fetch, load or store) and returns a full 32-bit word after a programmable number of wait cycles.
- Performs byte-lane placement and strobing for byte and half stores.
- Load extraction remains on the CPU side, using addr[1:0] and the instruction size bits.

Parameters:
- ADDR_W, 12: word-address bits; depth = 2**ADDR_W words (16 KiB default).
- LATENCY, 1: wait cycles between acceptance and response; legal range 0..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  CPU presents a request
- req_ready  out  1  responder can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = read/fetch
- req_addr  in  32  byte address
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- rsp_valid  out  1  one-cycle pulse; response data/status valid
- rsp_rdata  out  32  full aligned word at req_addr[ADDR_W+1:2]; 0 on error
- rsp_err  out  1  request rejected: misaligned, illegal size, or out of range

Behaviour:
- Reset values: req_ready=0 during reset and 1 in the first cycle after; rsp_valid=0, rsp_rdata=0, rsp_err=0; state=IDLE; wait counter=0.
- Memory array contents are not cleared by reset.
- Handshake: a request is accepted on a clock edge where req_valid && req_ready.
  - Address, we, size and wdata are captured into internal registers at acceptance.
  - CPU inputs are don't-care afterwards.
- FSM states:
  - IDLE: req_ready=1. On acceptance, go to WAIT if LATENCY>0, else RESP. Load counter with LATENCY-1.
  - WAIT: req_ready=0. Decrement the counter each cycle. Go to RESP when the counter is 0.
  - RESP: rsp_valid=1 for exactly this cycle, req_ready=0, then go to IDLE.
- Latency: rsp_valid asserts LATENCY+1 cycles after the acceptance edge. Back-to-back throughput is one request per LATENCY+2 cycles.
- Error checks are evaluated on the captured request:
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - size=3
  - addr[31:ADDR_W+2]!=0
  - On error: no array write, rsp_err=1, rsp_rdata=0.
- Store:
  - Array write occurs in the RESP cycle only, and only if there is no error.
  - Byte: wdata[7:0] goes to lane addr[1:0].
  - Half: wdata[15:0] goes to lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes.
  - Unstrobed lanes keep their old value.
  - rsp_rdata on a store returns the pre-write word.
- Read: rsp_rdata is the word read synchronously during the final WAIT cycle (or the acceptance cycle when LATENCY=0). Registered; stable only while rsp_valid=1, otherwise 0.
- req_valid is held high while in WAIT/RESP: ignored; the request is accepted on the first IDLE cycle.
- Reset mid-operation: any pending request is dropped and no write occurs. rsp_valid stays 0 and the FSM returns to IDLE.
- rsp_err and rsp_rdata return to 0 on the cycle after RESP.

Decomposition:
- Package otter_mem_pkg:
  - size enum (MEM_BYTE=0, MEM_HALF=1, MEM_WORD=2)
  - FSM state enum (IDLE, WAIT, RESP)
  - constant LATENCY_MAX=15
- Sub-module otter_lane_align (combinational):
  - Inputs: addr[1:0], size, wdata.
  - Outputs: 4-bit strobe, lane-placed 32-bit data, misalign flag.
- The top level holds the FSM, counter, capture registers and the byte-strobed array.

Test Plan:
- LATENCY=1, word store 0xDEADBEEF @0x100, then read @0x100 -> rsp_valid 2 cycles after each acceptance; rdata=0xDEADBEEF; err=0.
- Byte store 0xAA @0x101 over 0x11223344, read @0x100 -> 0x1122AA44. Then half store 0xBEEF @0x102 -> read 0xBEEFAA44.
- Word read @0x102, half store @0x103, size=3, addr=0x0001_0000 (ADDR_W=12) -> each gives rsp_err=1 and rdata=0; following read shows memory unchanged.
- LATENCY=0, req_valid held high for 4 reads -> accepted every 2nd cycle; req_ready toggles 1,0; each rsp_valid is exactly 1 cycle.
- LATENCY=3, rst asserted in the 2nd WAIT cycle of store 0x55 @0x200 -> no rsp_valid; req_ready=1 the cycle after rst deasserts; read @0x200 returns the prior contents.
- Store @0x300 with wdata=0x12345678 -> rsp_rdata carries the old word; the subsequent read returns 0x12345678.
